// File: rtl/sent_transmitter.sv
// SENT (SAE J2716) frame generator: sync, status, 1..MaxDatNibble_g data nibbles, CRC4.
// Ports: Clk, Reset_n (sync, active low), Start_i, NumDatNibble_i, Status_i, Data_i,
//   TickDivider_i (clocks per tick - 1), PauseTicks_i (SENT_TX_PAUSE_EN only),
//   Out_o (SENT line, idle high), Busy_o (frame running), Done_o (end-of-frame pulse).
// Optional feature macro: SENT_TX_PAUSE_EN adds a trailing pause pulse after the CRC nibble.
module sent_transmitter #(
    parameter int MaxDatNibble_g = 6,
    parameter int TickWidth_g    = 16
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        Start_i,
    input  logic [2:0]                  NumDatNibble_i,
    input  logic [3:0]                  Status_i,
    input  logic [MaxDatNibble_g*4-1:0] Data_i,
    input  logic [TickWidth_g-1:0]      TickDivider_i,
`ifdef SENT_TX_PAUSE_EN
    input  logic [9:0]                  PauseTicks_i,
`endif
    output logic                        Out_o,
    output logic                        Busy_o,
    output logic                        Done_o
);

    localparam int DW = MaxDatNibble_g * 4;

    typedef enum logic [2:0] {
        St_Idle,
        St_Sync,
        St_Status,
        St_Data,
        St_Crc,
        St_Pause
    } state_t;

    state_t                 state_q, state_d;
    logic [TickWidth_g-1:0] tick_cnt_q, tick_cnt_d;
    logic [TickWidth_g-1:0] div_q, div_d;
    logic [9:0]             pls_cnt_q, pls_cnt_d;
    logic [2:0]             nib_q, nib_d;
    logic [2:0]             num_q, num_d;
    logic [3:0]             status_q, status_d;
    logic [DW-1:0]          data_q, data_d;
    logic [3:0]             crc_q, crc_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef SENT_TX_PAUSE_EN
    logic [9:0]             pause_q, pause_d;
    logic [9:0]             pause_in;
`endif

    // One nibble through the x^4+x^3+x^2+1 CRC, MSB first.
    function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic [3:0] nib);
        logic [3:0] c;
        logic       fb;
        c = crc;
        for (int b = 3; b >= 0; b--) begin
            fb = c[3] ^ nib[b];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
        end
        return c;
    endfunction

    logic [2:0]    num_in;
    logic [3:0]    crc_in;
    logic [DW-1:0] crc_sh;

    // Clamp the nibble count and compute the CRC up front from the inputs,
    // so the result is latched together with the data on Start.
    always_comb begin
        num_in = NumDatNibble_i;
        if (NumDatNibble_i == 3'd0) begin
            num_in = 3'd1;
        end else if (int'(NumDatNibble_i) > MaxDatNibble_g) begin
            num_in = 3'(MaxDatNibble_g);
        end
        // Align the first (most significant used) nibble to the top.
        crc_sh = Data_i << (4 * (MaxDatNibble_g - int'(num_in)));
        crc_in = 4'h5;
        for (int k = 0; k < MaxDatNibble_g; k++) begin
            if (k < int'(num_in)) begin
                crc_in = crc_step(crc_in, crc_sh[DW-1 -: 4]);
            end
            crc_sh = crc_sh << 4;
        end
        // Augmenting zero nibble.
        crc_in = crc_step(crc_in, 4'h0);
    end

`ifdef SENT_TX_PAUSE_EN
    always_comb begin
        pause_in = PauseTicks_i;
        if (PauseTicks_i != 10'd0 && PauseTicks_i < 10'd12) begin
            pause_in = 10'd12;
        end
    end
`endif

    logic [DW-1:0] nib_sh;
    logic [3:0]    cur_nib;
    logic [9:0]    pls_len;
    logic          tick;
    logic          last;

    always_comb begin
        nib_sh  = data_q >> (4 * (int'(num_q) - 1 - int'(nib_q)));
        cur_nib = nib_sh[3:0];
    end

    always_comb begin
        pls_len = 10'd0;
        unique case (state_q)
            St_Sync:   pls_len = 10'd56;
            St_Status: pls_len = 10'd12 + {6'd0, status_q};
            St_Data:   pls_len = 10'd12 + {6'd0, cur_nib};
            St_Crc:    pls_len = 10'd12 + {6'd0, crc_q};
`ifdef SENT_TX_PAUSE_EN
            St_Pause:  pls_len = pause_q;
`endif
            default:   pls_len = 10'd0;
        endcase
    end

    assign tick = (tick_cnt_q == div_q);
    assign last = tick && (pls_cnt_q == pls_len - 10'd1);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        div_d      = div_q;
        pls_cnt_d  = pls_cnt_q;
        nib_d      = nib_q;
        num_d      = num_q;
        status_d   = status_q;
        data_d     = data_q;
        crc_d      = crc_q;
        out_d      = out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef SENT_TX_PAUSE_EN
        pause_d    = pause_q;
`endif
        if (state_q == St_Idle) begin
            tick_cnt_d = '0;
            pls_cnt_d  = '0;
            out_d      = 1'b1;
            busy_d     = 1'b0;
            if (Start_i) begin
                state_d  = St_Sync;
                div_d    = TickDivider_i;
                nib_d    = 3'd0;
                num_d    = num_in;
                status_d = Status_i;
                data_d   = Data_i;
                crc_d    = crc_in;
`ifdef SENT_TX_PAUSE_EN
                pause_d  = pause_in;
`endif
                out_d    = 1'b0;
                busy_d   = 1'b1;
            end
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (last) begin
                // Next pulse starts with its falling edge.
                pls_cnt_d = '0;
                out_d     = 1'b0;
                unique case (state_q)
                    St_Sync:   state_d = St_Status;
                    St_Status: begin
                        state_d = St_Data;
                        nib_d   = 3'd0;
                    end
                    St_Data: begin
                        if (nib_q == num_q - 3'd1) begin
                            state_d = St_Crc;
                        end else begin
                            nib_d = nib_q + 3'd1;
                        end
                    end
`ifdef SENT_TX_PAUSE_EN
                    St_Crc: begin
                        if (pause_q != 10'd0) begin
                            state_d = St_Pause;
                        end else begin
                            state_d = St_Idle;
                        end
                    end
`endif
                    default:   state_d = St_Idle;
                endcase
                if (state_d == St_Idle) begin
                    out_d  = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end else if (tick) begin
                pls_cnt_d = pls_cnt_q + 10'd1;
                out_d     = (pls_cnt_q >= 10'd4);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= St_Idle;
            tick_cnt_q <= '0;
            div_q      <= '0;
            pls_cnt_q  <= '0;
            nib_q      <= '0;
            num_q      <= '0;
            status_q   <= '0;
            data_q     <= '0;
            crc_q      <= '0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SENT_TX_PAUSE_EN
            pause_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            pls_cnt_q  <= pls_cnt_d;
            nib_q      <= nib_d;
            num_q      <= num_d;
            status_q   <= status_d;
            data_q     <= data_d;
            crc_q      <= crc_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SENT_TX_PAUSE_EN
            pause_q    <= pause_d;
`endif
        end
    end

    assign Out_o  = out_q;
    assign Busy_o = busy_q;
    assign Done_o = done_q;

endmodule
